// File: rtl/mc_ctrl_fsm.sv
// mc_ctrl_fsm
//   Multicycle control unit: fetch/decode/execute state machine plus ALU decode.
//   Drives the datapath muxes/enables and the FlagW/PCS/RegW/MemW requests consumed
//   by the conditional-execution stage. Outputs are Moore-decoded from the state
//   register; Op/Funct/Rd come from the instruction register.
//
//   Optional feature macro: MC_CTRL_MEMWAIT_EN
//     defined   -> MemReady input exists; FETCH, MEMRD and MEMWR wait for it.
//     undefined -> no MemReady port; every state lasts one cycle.
//
//   Ports
//     clk         rising-edge clock
//     reset       asynchronous, active-low
//     Op/Funct/Rd instruction fields instr[27:26], instr[25:20], instr[15:12]
//     MemReady    memory handshake (only with MC_CTRL_MEMWAIT_EN)
//     FlagW       [1]=NZ write, [0]=CV write
//     PCS         PC written by this instruction
//     RegW, MemW  register / memory write requests
//     IRWrite     instruction register load
//     NextPC      unconditional PC+4 update
//     AdrSrc      memory address select (0=PC, 1=ALU result)
//     ResultSrc   00=ALUOut, 01=Data, 10=ALUResult
//     ALUSrcA     0=RD1, 1=PC
//     ALUSrcB     00=RD2, 01=ExtImm, 10=const 4
//     ALUControl  00 ADD, 01 SUB, 10 AND, 11 ORR
//     ImmSrc      = Op
//     RegSrc      [0]=(Op==10), [1]=(Op==01)
//     State       current state (debug), zero-extended to STATE_W
//
//   state  | meaning
//   FETCH  | load IR from mem[PC], PC <= PC+4
//   DECODE | read register file, dispatch on Op
//   MEMADR | compute load/store address
//   MEMRD  | read data memory
//   MEMWB  | write loaded data to Rd
//   MEMWR  | write data memory
//   EXECR  | ALU op, register operand
//   EXECI  | ALU op, immediate operand
//   ALUWB  | write ALU result to Rd (suppressed for CMP)
//   BRANCH | compute branch target, write PC
module mc_ctrl_fsm #(
    parameter int STATE_W = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [1:0]         Op,
    input  logic [5:0]         Funct,
    input  logic [3:0]         Rd,
`ifdef MC_CTRL_MEMWAIT_EN
    input  logic               MemReady,
`endif
    output logic [1:0]         FlagW,
    output logic               PCS,
    output logic               RegW,
    output logic               MemW,
    output logic               IRWrite,
    output logic               NextPC,
    output logic               AdrSrc,
    output logic [1:0]         ResultSrc,
    output logic               ALUSrcA,
    output logic [1:0]         ALUSrcB,
    output logic [1:0]         ALUControl,
    output logic [1:0]         ImmSrc,
    output logic [1:0]         RegSrc,
    output logic [STATE_W-1:0] State
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXECR  = 4'd6,
        S_EXECI  = 4'd7,
        S_ALUWB  = 4'd8,
        S_BRANCH = 4'd9
    } state_t;

    state_t state_q;
    state_t state_d;

    logic mem_ready;
`ifdef MC_CTRL_MEMWAIT_EN
    assign mem_ready = MemReady;
`else
    assign mem_ready = 1'b1;
`endif

    logic       ir_write, next_pc, reg_w_raw, mem_w_raw, branch, alu_op;
    logic [1:0] alu_ctl;
    logic       add_sub;
    logic       is_cmp;

    assign is_cmp = (Funct[4:1] == 4'b1010);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= S_FETCH;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d    = S_FETCH;
        ir_write   = 1'b0;
        next_pc    = 1'b0;
        AdrSrc     = 1'b0;
        ResultSrc  = 2'b00;
        ALUSrcA    = 1'b0;
        ALUSrcB    = 2'b00;
        alu_op     = 1'b0;
        reg_w_raw  = 1'b0;
        mem_w_raw  = 1'b0;
        branch     = 1'b0;
        case (state_q)
            S_FETCH: begin
                state_d   = mem_ready ? S_DECODE : S_FETCH;
                ir_write  = mem_ready;
                next_pc   = mem_ready;
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
            end
            S_DECODE: begin
                case (Op)
                    2'b00:   state_d = Funct[5] ? S_EXECI : S_EXECR;
                    2'b01:   state_d = S_MEMADR;
                    2'b10:   state_d = S_BRANCH;
                    default: state_d = S_FETCH;
                endcase
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
            end
            S_MEMADR: begin
                state_d = Funct[0] ? S_MEMRD : S_MEMWR;
                ALUSrcB = 2'b01;
            end
            S_MEMRD: begin
                state_d = mem_ready ? S_MEMWB : S_MEMRD;
                AdrSrc  = 1'b1;
            end
            S_MEMWB: begin
                state_d   = S_FETCH;
                ResultSrc = 2'b01;
                reg_w_raw = 1'b1;
            end
            S_MEMWR: begin
                // MemW stays up for the whole wait so the memory sees a stable request
                state_d   = mem_ready ? S_FETCH : S_MEMWR;
                AdrSrc    = 1'b1;
                mem_w_raw = 1'b1;
            end
            S_EXECR: begin
                state_d = S_ALUWB;
                alu_op  = 1'b1;
            end
            S_EXECI: begin
                state_d = S_ALUWB;
                ALUSrcB = 2'b01;
                alu_op  = 1'b1;
            end
            S_ALUWB: begin
                state_d   = S_FETCH;
                reg_w_raw = ~is_cmp;
            end
            S_BRANCH: begin
                state_d   = S_FETCH;
                ALUSrcB   = 2'b01;
                ResultSrc = 2'b10;
                branch    = 1'b1;
            end
            default: state_d = S_FETCH;
        endcase
    end

    always_comb begin
        alu_ctl = 2'b00;
        add_sub = 1'b0;
        case (Funct[4:1])
            4'b0100: begin alu_ctl = 2'b00; add_sub = 1'b1; end
            4'b0010: begin alu_ctl = 2'b01; add_sub = 1'b1; end
            4'b0000: alu_ctl = 2'b10;
            4'b1100: alu_ctl = 2'b11;
            4'b1010: begin alu_ctl = 2'b01; add_sub = 1'b1; end
            default: alu_ctl = 2'b00;
        endcase
    end

    // Enables are gated by reset directly so an assertion mid-instruction
    // kills any write in the same cycle, without waiting for a clock edge.
    assign IRWrite    = ir_write & reset;
    assign NextPC     = next_pc & reset;
    assign RegW       = reg_w_raw & reset;
    assign MemW       = mem_w_raw & reset;
    assign PCS        = (((Rd == 4'd15) & reg_w_raw) | branch) & reset;
    assign FlagW      = {2{alu_op & reset}} & {Funct[0], Funct[0] & add_sub};
    assign ALUControl = alu_op ? alu_ctl : 2'b00;
    assign ImmSrc     = Op;
    assign RegSrc     = {(Op == 2'b01), (Op == 2'b10)};
    assign State      = STATE_W'(state_q);

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
module tb_mc_ctrl_fsm;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [1:0] Op = 2'b00;
    logic [5:0] Funct = 6'd0;
    logic [3:0] Rd = 4'd0;
`ifdef MC_CTRL_MEMWAIT_EN
    logic       MemReady = 1'b1;
`endif
    logic [1:0] FlagW;
    logic       PCS, RegW, MemW, IRWrite, NextPC, AdrSrc, ALUSrcA;
    logic [1:0] ResultSrc, ALUSrcB, ALUControl, ImmSrc, RegSrc;
    logic [3:0] State;

    int n_chk  = 0;
    int n_pass = 0;

    mc_ctrl_fsm #(.STATE_W(4)) dut (
        .clk(clk),
        .reset(reset),
        .Op(Op),
        .Funct(Funct),
        .Rd(Rd),
`ifdef MC_CTRL_MEMWAIT_EN
        .MemReady(MemReady),
`endif
        .FlagW(FlagW),
        .PCS(PCS),
        .RegW(RegW),
        .MemW(MemW),
        .IRWrite(IRWrite),
        .NextPC(NextPC),
        .AdrSrc(AdrSrc),
        .ResultSrc(ResultSrc),
        .ALUSrcA(ALUSrcA),
        .ALUSrcB(ALUSrcB),
        .ALUControl(ALUControl),
        .ImmSrc(ImmSrc),
        .RegSrc(RegSrc),
        .State(State)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    endtask

    // Reference model: an instruction is a list of state codes whose length is
    // the documented latency; each output is expressed by its position in that list.
    // Called with the unit in FETCH, just after a clock edge.
    task automatic run_instr(input logic [1:0] op, input logic [5:0] f, input logic [3:0] rd);
        int  seq[$];
        bit  dp, br, ldr, str, cmp, addsub, regw, pcs;
        int  last, alu_exp, flag_exp, rs_exp, srcb_exp;
        logic [3:0] cmd;
        Op = op; Funct = f; Rd = rd;
        dp  = (op == 2'd0);
        br  = (op == 2'd2);
        ldr = (op == 2'd1) && f[0];
        str = (op == 2'd1) && !f[0];
        cmd = f[4:1];
        cmp    = (cmd == 4'b1010);
        addsub = (cmd == 4'b0100) || (cmd == 4'b0010) || cmp;
        if (cmd == 4'b0010 || cmp) alu_exp = 1;
        else if (cmd == 4'b0000)   alu_exp = 2;
        else if (cmd == 4'b1100)   alu_exp = 3;
        else                       alu_exp = 0;
        flag_exp = (f[0] ? 2 : 0) + ((f[0] && addsub) ? 1 : 0);
        seq = '{0, 1};
        if (dp) begin seq.push_back(f[5] ? 7 : 6); seq.push_back(8); end
        if (ldr) begin seq.push_back(2); seq.push_back(3); seq.push_back(4); end
        if (str) begin seq.push_back(2); seq.push_back(5); end
        if (br) seq.push_back(9);
        last = seq.size() - 1;
        for (int k = 0; k <= last; k++) begin
            @(negedge clk);
            regw = (k == last) && ((dp && !cmp) || ldr);
            pcs  = (br && k == last) || (regw && rd == 4'd15);
            if (k <= 1 || (br && k == 2)) rs_exp = 2;
            else if (ldr && k == 4)       rs_exp = 1;
            else                          rs_exp = 0;
            if (k <= 1) srcb_exp = 2;
            else if (k == 2 && (op == 2'd1 || br || (dp && f[5]))) srcb_exp = 1;
            else srcb_exp = 0;
            check_val("state",     State,      seq[k]);
            check_val("irwrite",   IRWrite,    k == 0);
            check_val("nextpc",    NextPC,     k == 0);
            check_val("regw",      RegW,       regw);
            check_val("memw",      MemW,       str && k == last);
            check_val("pcs",       PCS,        pcs);
            check_val("flagw",     FlagW,      (dp && k == 2) ? flag_exp : 0);
            check_val("aluctl",    ALUControl, (dp && k == 2) ? alu_exp : 0);
            check_val("adrsrc",    AdrSrc,     (ldr || str) && k == 3);
            check_val("resultsrc", ResultSrc,  rs_exp);
            check_val("alusrca",   ALUSrcA,    k <= 1);
            check_val("alusrcb",   ALUSrcB,    srcb_exp);
            check_val("immsrc",    ImmSrc,     op);
            check_val("regsrc",    RegSrc,     ((op == 2'd1) ? 2 : 0) + ((op == 2'd2) ? 1 : 0));
            @(posedge clk); #1;
        end
    endtask

    initial begin
        logic [1:0] r_op;
        logic [3:0] r_cmd, r_rd;
        logic [5:0] r_f;
        logic [3:0] cmd_tab [5];
        cmd_tab = '{4'b0100, 4'b0010, 4'b0000, 4'b1100, 4'b1010};

        // reset held for 3 cycles with arbitrary instruction fields
        Op = 2'd0; Funct = 6'b001001; Rd = 4'd15;
        repeat (3) begin
            @(negedge clk);
            check_val("rst_state",   State,   0);
            check_val("rst_irwrite", IRWrite, 0);
            check_val("rst_nextpc",  NextPC,  0);
            check_val("rst_regw",    RegW,    0);
            check_val("rst_memw",    MemW,    0);
            check_val("rst_pcs",     PCS,     0);
            check_val("rst_flagw",   FlagW,   0);
            check_val("rst_alusrcb", ALUSrcB, 2);
        end
        @(posedge clk); #1;
        reset = 1'b1;

        // directed: ADDS, LDR, STR, B, ADD Rd=15, CMP, undefined, ORR imm, LDR to PC
        run_instr(2'b00, 6'b001001, 4'd1);
        run_instr(2'b01, 6'b011001, 4'd2);
        run_instr(2'b01, 6'b011000, 4'd3);
        run_instr(2'b10, 6'b000000, 4'd0);
        run_instr(2'b00, 6'b001000, 4'd15);
        run_instr(2'b00, 6'b010101, 4'd15);
        run_instr(2'b11, 6'b111111, 4'd15);
        run_instr(2'b00, 6'b111001, 4'd4);
        run_instr(2'b01, 6'b000001, 4'd15);

        // reset asserted inside MEMWR must drop MemW immediately
        Op = 2'b01; Funct = 6'b011000; Rd = 4'd5;
        repeat (3) begin @(posedge clk); #1; end
        @(negedge clk);
        check_val("memwr_state", State, 5);
        check_val("memwr_memw",  MemW,  1);
        reset = 1'b0;
        #1;
        check_val("abort_memw",  MemW,  0);
        check_val("abort_state", State, 0);
        @(posedge clk); #1;
        check_val("abort_hold", State, 0);
        reset = 1'b1;

`ifdef MC_CTRL_MEMWAIT_EN
        // LDR stalled in MEMRD for 3 cycles of MemReady=0
        Op = 2'b01; Funct = 6'b011001; Rd = 4'd6;
        repeat (3) begin @(posedge clk); #1; end
        MemReady = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_val("wait_state", State, 3);
            @(posedge clk); #1;
        end
        MemReady = 1'b1;
        @(negedge clk);
        check_val("wait_last", State, 3);
        @(posedge clk); #1;
        @(negedge clk);
        check_val("wait_wb", State, 4);
        check_val("wait_regw", RegW, 1);
        @(posedge clk); #1;
`endif

        // randomized instruction stream
        for (int n = 0; n < 80; n++) begin
            r_op = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 5) == 5) r_cmd = 4'($urandom_range(0, 15));
            else r_cmd = cmd_tab[$urandom_range(0, 4)];
            r_f = {1'($urandom_range(0, 1)), r_cmd, 1'($urandom_range(0, 1))};
            r_rd = ($urandom_range(0, 3) == 0) ? 4'd15 : 4'($urandom_range(0, 15));
            run_instr(r_op, r_f, r_rd);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
